// File: rtl/io_loader.sv
// io_loader: host word stream -> command parser -> sequential memory writes.
// Define IO_LOADER_CHECKSUM_EN to require a trailing checksum word per WRITE.
module io_loader #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] MAGIC      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] din,
    input  logic        data_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        cpu_hold,
    output logic        busy,
    output logic [2:0]  err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;

`ifdef IO_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR, S_ADDR, S_DATA, S_ACK, S_CSUM} state_t;
    localparam state_t S_END = S_CSUM;
`else
    typedef enum logic [1:0] {S_HDR, S_ADDR, S_DATA, S_ACK} state_t;
    localparam state_t S_END = S_HDR;
`endif

    state_t      state_q, state_d;
    logic        dr_q;
    logic [31:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    logic        empty, full, push, push_ok, pop;
    logic [31:0] head;
    logic        is_write, is_run;
    logic [31:0] addr_q, wdata_q;
    logic [15:0] cnt_q;
    logic        req_q, hold_q, err_proto, err_ovf, err_csum;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign push    = data_ready & ~dr_q;
    assign push_ok = push & (~full | pop);
    assign head    = fifo_mem[rp[AW-1:0]];
    assign is_write = (head[31:24] == MAGIC) && (head[23:16] == CMD_WRITE);
    assign is_run   = (head[31:24] == MAGIC) && (head[23:16] == CMD_RUN);

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wp[AW-1:0]] <= din;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_HDR: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (is_write)
                        state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = (cnt_q == 16'd0) ? S_END : S_DATA;
                end
            end
            S_DATA: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (mem_ack)
                    state_d = (cnt_q == 16'd1) ? S_END : S_DATA;
            end
`ifdef IO_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_HDR;
                end
            end
`endif
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HDR;
            dr_q      <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            hold_q    <= 1'b1;
            err_proto <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            state_q <= state_d;
            dr_q    <= data_ready;
            if (push_ok)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (push & full & ~pop)
                err_ovf <= 1'b1;
            unique case (state_q)
                S_HDR: begin
                    if (pop) begin
                        if (is_write) begin
                            cnt_q     <= head[15:0];
                            hold_q    <= 1'b1;
                            err_proto <= 1'b0;
                        end else if (is_run) begin
                            hold_q    <= 1'b0;
                            err_proto <= 1'b0;
                        end else begin
                            err_proto <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (pop)
                        addr_q <= head & ~32'h3;
                end
                S_DATA: begin
                    if (pop) begin
                        wdata_q <= head;
                        req_q   <= 1'b1;
                    end
                end
                S_ACK: begin
                    if (mem_ack) begin
                        req_q  <= 1'b0;
                        addr_q <= addr_q + 32'd4;
                        cnt_q  <= cnt_q - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IO_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    // Running sum covers the base address and every data word of one WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            err_csum <= 1'b0;
        end else if (pop) begin
            unique case (state_q)
                S_HDR:   if (is_write) sum_q <= '0;
                S_ADDR:  sum_q <= sum_q + (head & ~32'h3);
                S_DATA:  sum_q <= sum_q + head;
                S_CSUM:  if (head != sum_q) err_csum <= 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign err_csum = 1'b0;
`endif

    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign busy      = (state_q != S_HDR) || !empty;
    assign err       = {err_csum, err_ovf, err_proto};

endmodule

// File: tb/tb_io_loader.sv
// Self-checking bench for io_loader: vector table, directed corner cases,
// and a randomized command stream checked against a stream-level parser.
module tb_io_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din = '0;
    logic        data_ready = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        cpu_hold;
    logic        busy;
    logic [2:0]  err;

`ifdef IO_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    always #5 clk = ~clk;

    io_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .data_ready(data_ready),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [31:0] w [3];
        int          nw;
        logic        e0;
        logic        hold;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    wr_t  got [$];
    wr_t  exp_q [$];
    int   ack_mode = 0;
    int   wait_cnt = 0;
    logic pend = 1'b0;
    logic [31:0] pa = '0;
    logic [31:0] pd = '0;
    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Memory-side agent: drives mem_ack, logs accepted writes,
    // and checks the request is held steady while unacknowledged.
    always @(negedge clk) begin : mem_agent
        logic a;
        case (ack_mode)
            0: a = 1'b1;
            1: a = 1'b0;
            default: a = (wait_cnt >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        endcase
        if (rst_n && pend) begin
            chk("req_held", 32'(mem_req), 32'd1);
            chk("addr_stable", mem_addr, pa);
            chk("wdata_stable", mem_wdata, pd);
        end
        if (rst_n && mem_req && a)
            got.push_back('{mem_addr, mem_wdata});
        mem_ack  <= a;
        pend     <= rst_n && mem_req && !a;
        pa       <= mem_addr;
        pd       <= mem_wdata;
        wait_cnt <= (mem_req && !a) ? wait_cnt + 1 : 0;
    end

    task automatic send(input logic [31:0] w, input int gap);
        @(negedge clk);
        din = w;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 400 && busy; k++)
            @(negedge clk);
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_writes(input string nm);
        chk({nm, "_nwr"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk({nm, "_addr"}, got[i].a, exp_q[i].a);
            chk({nm, "_data"}, got[i].d, exp_q[i].d);
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        data_ready = 1'b0;
        din = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got.delete();
        exp_q.delete();
    endtask

    task automatic set_vec(input int i, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2,
                           input int nw, input logic e0, input logic hold);
        vecs[i].w[0] = w0;
        vecs[i].w[1] = w1;
        vecs[i].w[2] = w2;
        vecs[i].nw   = nw;
        vecs[i].e0   = e0;
        vecs[i].hold = hold;
    endtask

    // Reference: walk the accepted word stream as the host protocol reads it
    function automatic void run_model(input logic [31:0] ws [$],
                                      inout logic hold, inout logic e0,
                                      inout logic e2);
        int i;
        i = 0;
        while (i < ws.size()) begin
            logic [31:0] h;
            h = ws[i];
            i++;
            if (h[31:24] != 8'hA5 || (h[23:16] != 8'h01 && h[23:16] != 8'h02)) begin
                e0 = 1'b1;
            end else if (h[23:16] == 8'h02) begin
                hold = 1'b0;
                e0 = 1'b0;
            end else begin
                logic [31:0] base;
                logic [31:0] s;
                int n;
                n = int'(h[15:0]);
                hold = 1'b0 | 1'b1;
                e0 = 1'b0;
                base = ws[i] & ~32'h3;
                i++;
                s = base;
                for (int k = 0; k < n; k++) begin
                    exp_q.push_back('{base + 32'(4 * k), ws[i]});
                    s = s + ws[i];
                    i++;
                end
                if (CS != 0) begin
                    if (ws[i] != s)
                        e2 = 1'b1;
                    i++;
                end
            end
        end
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] ws [$];
        logic [31:0] a, d, s;
        int          n, kind;
        logic        mh, me0, me2;

        apply_reset();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // basic WRITE with immediate ack
        ack_mode = 0;
        send(32'hA5010003, 0);
        send(32'h00000102, 0);
        send(32'd11, 0);
        send(32'd22, 0);
        send(32'd33, 0);
        if (CS != 0) send(32'h00000142, 0);
        wait_idle("basic");
        exp_q.push_back('{32'h100, 32'd11});
        exp_q.push_back('{32'h104, 32'd22});
        exp_q.push_back('{32'h108, 32'd33});
        check_writes("basic");
        chk("basic_hold", 32'(cpu_hold), 32'd1);
        chk("basic_err", 32'(err), 32'd0);

        // RUN: hold drops the cycle after the pop
        @(negedge clk);
        din = 32'hA5020000;
        data_ready = 1'b1;
        @(negedge clk);
        chk("run_hold_pushed", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        chk("run_hold_popped", 32'(cpu_hold), 32'd0);
        data_ready = 1'b0;
        wait_idle("run");

        // single-command header vectors
        set_vec(0, 32'hA5020000, 0, 0, 1, 1'b0, 1'b0);
        set_vec(1, 32'h5A010001, 0, 0, 1, 1'b1, 1'b0);
        set_vec(2, 32'hA5010000, 32'h40, 32'h40, 2 + CS, 1'b0, 1'b1);
        set_vec(3, 32'hA5030000, 0, 0, 1, 1'b1, 1'b1);
        set_vec(4, 32'hA5020005, 0, 0, 1, 1'b0, 1'b0);
        set_vec(5, 32'hA5FF0000, 0, 0, 1, 1'b1, 1'b0);
        set_vec(6, 32'hA5020000, 0, 0, 1, 1'b0, 1'b0);
        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < vecs[v].nw; j++)
                send(vecs[v].w[j], 0);
            wait_idle($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_err0", v), 32'(err[0]), 32'(vecs[v].e0));
            chk($sformatf("vec%0d_hold", v), 32'(cpu_hold), 32'(vecs[v].hold));
            check_writes($sformatf("vec%0d", v));
        end

        // back-pressure: stalled ack, FIFO fills, 6th data word dropped
        ack_mode = 1;
        send(32'hA5010008, 0);
        send(32'h00000200, 0);
        for (int i = 1; i <= 6; i++)
            send(32'h1000 + 32'(i), 0);
        repeat (38) @(negedge clk);
        chk("bp_req", 32'(mem_req), 32'd1);
        chk("bp_addr", mem_addr, 32'h200);
        chk("bp_wdata", mem_wdata, 32'h1001);
        chk("bp_ovf", 32'(err[1]), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        ack_mode = 0;
        repeat (12) @(negedge clk);
        for (int i = 7; i <= 9; i++)
            send(32'h1000 + 32'(i), 0);
        s = 32'h200;
        for (int i = 1; i <= 9; i++) begin
            if (i != 6) begin
                exp_q.push_back('{32'h200 + 32'(4 * (exp_q.size())), 32'h1000 + 32'(i)});
                s = s + 32'h1000 + 32'(i);
            end
        end
        if (CS != 0) send(s, 0);
        wait_idle("bp");
        check_writes("bp");
        chk("bp_err_sticky", 32'(err), 32'b010);

        // reset while waiting in S_ACK
        ack_mode = 1;
        send(32'hA5010002, 0);
        send(32'h00000400, 0);
        send(32'h000000AA, 0);
        for (int k = 0; k < 20 && !mem_req; k++)
            @(negedge clk);
        chk("ack_rst_req_seen", 32'(mem_req), 32'd1);
        send(32'h000000BB, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ack_rst_req", 32'(mem_req), 32'd0);
        chk("ack_rst_hold", 32'(cpu_hold), 32'd1);
        chk("ack_rst_busy", 32'(busy), 32'd0);
        chk("ack_rst_err", 32'(err), 32'd0);
        chk("ack_rst_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_mode = 0;
        got.delete();
        repeat (10) @(negedge clk);
        chk("ack_rst_quiet", 32'(busy), 32'd0);
        check_writes("ack_rst");

        // level held high: one push only
        @(negedge clk);
        din = 32'hA5010001;
        data_ready = 1'b1;
        repeat (10) @(negedge clk);
        data_ready = 1'b0;
        chk("lvl_busy", 32'(busy), 32'd1);
        chk("lvl_req", 32'(mem_req), 32'd0);
        send(32'h00000300, 0);
        send(32'h00000077, 0);
        if (CS != 0) send(32'h00000377, 0);
        wait_idle("lvl");
        exp_q.push_back('{32'h300, 32'h77});
        check_writes("lvl");

`ifdef IO_LOADER_CHECKSUM_EN
        send(32'hA5010002, 0);
        send(32'h10, 0);
        send(32'h1, 0);
        send(32'h2, 0);
        send(32'h13, 0);
        wait_idle("cs_good");
        chk("cs_good_err2", 32'(err[2]), 32'd0);
        send(32'hA5010002, 0);
        send(32'h10, 0);
        send(32'h1, 0);
        send(32'h2, 0);
        send(32'h14, 0);
        wait_idle("cs_bad");
        chk("cs_bad_err2", 32'(err[2]), 32'd1);
        exp_q.push_back('{32'h10, 32'h1});
        exp_q.push_back('{32'h14, 32'h2});
        exp_q.push_back('{32'h10, 32'h1});
        exp_q.push_back('{32'h14, 32'h2});
        check_writes("cs");
`endif

        // randomized command stream with random ack latency
        apply_reset();
        ack_mode = 2;
        for (int c = 0; c < 14; c++) begin
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                ws.push_back(32'h5A000000 | 32'($urandom_range(0, 255)));
            end else if (kind == 1) begin
                ws.push_back(32'hA5020000 | 32'($urandom_range(0, 65535)));
            end else begin
                n = (c == 5) ? 3 : $urandom_range(0, 3);
                ws.push_back(32'hA5010000 | 32'(n));
                a = (c == 5) ? 32'hFFFFFFF9 : $urandom;
                ws.push_back(a);
                s = a & ~32'h3;
                for (int k = 0; k < n; k++) begin
                    d = $urandom;
                    ws.push_back(d);
                    s = s + d;
                end
                if (CS != 0)
                    ws.push_back(s + 32'($urandom_range(0, 3) == 0));
            end
        end
        foreach (ws[i])
            send(ws[i], 4);
        wait_idle("rnd");
        mh = 1'b1;
        me0 = 1'b0;
        me2 = 1'b0;
        run_model(ws, mh, me0, me2);
        check_writes("rnd");
        chk("rnd_hold", 32'(cpu_hold), 32'(mh));
        chk("rnd_err", 32'(err), 32'({me2, 1'b0, me0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_loader.md
# io_loader

Downstream consumer of the UART word decoder in the io_hub. It takes each assembled 32-bit word and parses it against a small host command protocol, then turns WRITE commands into sequential 32-bit memory write transactions. The target is the selen core's memory. A RUN command releases the core from its hold-in-reset. A word FIFO decouples UART word arrival from memory-port back-pressure.

## Interface
- FIFO_DEPTH, 4, word FIFO entries; power of two, ≥2
- MAGIC, 8'hA5, required header byte [31:24]

- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  reset; asynchronous and active-low. One clock domain only.
- din  in  32  word from decoder, little-endian assembled
- data_ready  in  1  decoder word-valid level. The 0→1 edge marks a new word, and din is stable while it is high.
- mem_req  out  1  write request
- mem_addr  out  32  byte address, word aligned
- mem_wdata  out  32  write data
- mem_ack  in  1  write accepted; sampled only while mem_req=1
- cpu_hold  out  1  holds core in reset while 1
- busy  out  1  FSM not in S_HDR, or FIFO not empty
- err  out  3  sticky flags: [0] protocol, [1] overflow, [2] checksum

## Operation
- **Word capture**
  - Register dr_q <= data_ready.
  - Push din into the FIFO in the cycle where data_ready & ~dr_q.
  - A level held high produces exactly one push.
- **FIFO push rules**
  - Full with no pop in the same cycle: the word is dropped and err[1] is set.
  - Full with a pop in the same cycle: the push is accepted.
- **Header word:** [31:24] magic, [23:16] cmd, [15:0] count N.
  - cmd 0x01 = WRITE.
  - cmd 0x02 = RUN; N is ignored.
- **FSM states:** S_HDR, S_ADDR, S_DATA, S_ACK, plus S_CSUM (macro only).
- **S_HDR:** pop one word when the FIFO is non-empty.
  - Magic ≠ MAGIC, or unknown cmd: set err[0] and stay in S_HDR.
  - WRITE: cnt <= N, cpu_hold <= 1, clear err[0], go to S_ADDR.
  - RUN: cpu_hold <= 0, clear err[0], stay in S_HDR.
- **S_ADDR:** pop a word, addr <= word & ~32'h3.
  - N==0: go to S_CSUM if enabled, otherwise S_HDR.
  - Otherwise go to S_DATA.
- **S_DATA:** pop a word into the mem_wdata register, assert mem_req, go to S_ACK.
- **S_ACK:** hold mem_req, mem_addr and mem_wdata stable until mem_ack=1. Then:
  - mem_req <= 0, addr <= addr+4 (wraps mod 2^32), cnt <= cnt-1.
  - cnt was 1: go to S_CSUM if enabled, otherwise S_HDR.
  - Otherwise go to S_DATA.
- **Error clearing:** err[1] and err[2] clear only on reset. err[0] clears on the next valid header.
- **Reset (including mid-transfer):** all outputs and state return to reset values and the FIFO empties. Any in-flight mem_req is abandoned.

## Timing
- **Reset values:**
  - mem_req=0, mem_addr=0, mem_wdata=0
  - cpu_hold=1, busy=0, err=0
  - FSM=S_HDR, FIFO empty, dr_q=0
- **Push:** data_ready rising edge sampled at cycle t → word in FIFO at t+1. The FSM can pop at t+1.
- **Pop and request:** pop in S_DATA at cycle t → mem_req=1 from t+1.
- **Acknowledge:** ack sampled at cycle t → mem_req=0 at t+1.
  - The next S_DATA pop can happen at t+1, so mem_req re-asserts at t+2.
  - A minimum of one idle cycle separates back-to-back requests.
- **Ack latency:** mem_ack at the same edge as mem_req rising is allowed, giving a 1-cycle request. mem_ack while mem_req=0 is ignored.
- **Best-case throughput:** header → first mem_req takes 4 cycles after the header push, with the FIFO pre-filled.
- **cpu_hold:** changes in the cycle after the header pop.

## Configuration
- IO_LOADER_CHECKSUM_EN defined:
  - After the last data word of a WRITE, the FSM enters S_CSUM.
  - It pops one word and compares it with the mod-2^32 sum of the data words plus the base address. It then returns to S_HDR.
  - Mismatch sets err[2].
  - The sum register resets to 0 on each WRITE header.
- Undefined:
  - S_CSUM and the sum logic are absent; no checksum word is consumed.
  - err[2] is tied to 0.

## Test plan
- **Basic WRITE:** send header 32'hA5010003, address 32'h00000102, data 11, 22, 33; mem_ack=1 immediately.
  - Expect writes to 0x100=11, 0x104=22, 0x108=33.
  - Expect cpu_hold=1, err=0, then busy=0.
- **RUN:** send 32'hA5020000 after the basic WRITE → cpu_hold falls to 0 one cycle after the pop.
- **Bad header:** send 32'h5A010001 → err[0]=1 and no mem_req. A following valid WRITE clears err[0].
- **Back-pressure:** hold mem_ack=0 for 50 cycles during an N=8 WRITE with words streaming in.
  - mem_addr and mem_wdata stay stable while waiting.
  - The FIFO fills and the (FIFO_DEPTH+1)th pending word is dropped, setting err[1].
- **Level and reset:**
  - Hold data_ready high for 10 cycles → exactly one push.
  - Assert rst_n=0 during S_ACK → mem_req=0 and cpu_hold=1 immediately, FIFO empty.
- **Checksum (macro on):** WRITE N=2 at 0x10 with data 1, 2.
  - Checksum word 0x13 → err[2]=0.
  - Checksum word 0x14 → err[2]=1.
